// File: rtl/inert_intf_if.sv
// ---------------------------------------------------------------------------
// inert_intf_if
// Bundles the signals that run between the inertial command sequencer and the
// 16-bit SPI monarch.
//   wrt        : one-cycle pulse that starts an SPI transaction
//   cmd        : 16-bit command word for the monarch's wt_data input
//   done       : monarch transaction-complete level; cleared by the monarch
//                in the cycle after wrt
//   inert_data : monarch rd_data; only [7:0] carries sensor data
// Modports:
//   master : the sequencer side (drives wrt/cmd, consumes done/inert_data)
//   slave  : the SPI monarch side
// ---------------------------------------------------------------------------
interface inert_intf_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] inert_data;

  modport master (
    output wrt,
    output cmd,
    input  done,
    input  inert_data
  );

  modport slave (
    input  wrt,
    input  cmd,
    output done,
    output inert_data
  );
endinterface

// File: rtl/inert_intf.sv
// ---------------------------------------------------------------------------
// inert_intf
// SPI command sequencer for the 6-axis inertial sensor. After a power-on wait
// it issues four configuration writes, then on every data-ready interrupt it
// reads pitch-rate low/high and Z-acceleration low/high and presents both
// assembled words together with a one-cycle valid strobe.
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   INT        : sensor data-ready interrupt (asynchronous, active-high level)
//   spi        : SPI monarch bus (wrt, cmd, done, inert_data), master side
//   ptch_rt    : signed pitch rate {high byte, low byte}
//   AZ         : signed Z acceleration {high byte, low byte}
//   vld        : one-cycle strobe, ptch_rt and AZ just updated
//   init_done  : high once all configuration writes have completed
// ---------------------------------------------------------------------------
module inert_intf #(
  parameter int RST_WAIT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               INT,
  inert_intf_if.master       spi,
  output logic signed [15:0] ptch_rt,
  output logic signed [15:0] AZ,
  output logic               vld,
  output logic               init_done
);

  // Each *_WAIT state is encoded as its *_SEND state plus one, which lets the
  // SEND states share a single transition below.
  typedef enum logic [4:0] {
    INIT_WAIT = 5'd0,
    CFG0_SEND = 5'd1,  CFG0_WAIT = 5'd2,
    CFG1_SEND = 5'd3,  CFG1_WAIT = 5'd4,
    CFG2_SEND = 5'd5,  CFG2_WAIT = 5'd6,
    CFG3_SEND = 5'd7,  CFG3_WAIT = 5'd8,
    IDLE      = 5'd9,
    RPL_SEND  = 5'd10, RPL_WAIT  = 5'd11,
    RPH_SEND  = 5'd12, RPH_WAIT  = 5'd13,
    RAL_SEND  = 5'd14, RAL_WAIT  = 5'd15,
    RAH_SEND  = 5'd16, RAH_WAIT  = 5'd17
  } state_t;

  state_t                  state;
  logic [RST_WAIT_W-1:0]   timer;
  logic                    int_ff1;
  logic                    int_ff2;
  logic [7:0]              p_lo;
  logic [7:0]              p_hi;
  logic [7:0]              az_lo;

  // The monarch returns a full 16-bit word but the sensor only drives a byte.
  logic unused_rd_hi;
  assign unused_rd_hi = ^spi.inert_data[15:8];

  // Interrupt synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_ff1 <= 1'b0;
      int_ff2 <= 1'b0;
    end else begin
      int_ff1 <= INT;
      int_ff2 <= int_ff1;
    end
  end

  // Power-on wait timer. The FSM leaves INIT_WAIT on all-ones, so the
  // counter never needs to saturate; it is held clear elsewhere so that any
  // re-entry to INIT_WAIT gets a full wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (state == INIT_WAIT) begin
      timer <= timer + 1'b1;
    end else begin
      timer <= '0;
    end
  end

  // Byte holding registers, captured as each read completes
  always_ff @(posedge clk) begin
    if (spi.done) begin
      if (state == RPL_WAIT) p_lo  <= spi.inert_data[7:0];
      if (state == RPH_WAIT) p_hi  <= spi.inert_data[7:0];
      if (state == RAL_WAIT) az_lo <= spi.inert_data[7:0];
    end
  end

  // Sequencer FSM with registered wrt/cmd/vld/init_done. wrt is raised on the
  // transition into a SEND state, so it is high exactly during that state;
  // cmd only changes at those transitions and so stays stable until done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT_WAIT;
      spi.wrt   <= 1'b0;
      spi.cmd   <= 16'h0000;
      ptch_rt   <= '0;
      AZ        <= '0;
      vld       <= 1'b0;
      init_done <= 1'b0;
    end else begin
      spi.wrt <= 1'b0;
      vld     <= 1'b0;
      case (state)
        INIT_WAIT: if (&timer) begin
          state   <= CFG0_SEND;
          spi.wrt <= 1'b1;
          spi.cmd <= 16'h0D02;
        end
        CFG0_SEND, CFG1_SEND, CFG2_SEND, CFG3_SEND,
        RPL_SEND, RPH_SEND, RAL_SEND, RAH_SEND:
          state <= state_t'(state + 5'd1);
        CFG0_WAIT: if (spi.done) begin
          state   <= CFG1_SEND;
          spi.wrt <= 1'b1;
          spi.cmd <= 16'h1053;
        end
        CFG1_WAIT: if (spi.done) begin
          state   <= CFG2_SEND;
          spi.wrt <= 1'b1;
          spi.cmd <= 16'h1150;
        end
        CFG2_WAIT: if (spi.done) begin
          state   <= CFG3_SEND;
          spi.wrt <= 1'b1;
          spi.cmd <= 16'h1460;
        end
        CFG3_WAIT: if (spi.done) begin
          state     <= IDLE;
          init_done <= 1'b1;
        end
        // Level-triggered: INT still high on return here starts another read.
        IDLE: if (int_ff2) begin
          state   <= RPL_SEND;
          spi.wrt <= 1'b1;
          spi.cmd <= 16'hA200;
        end
        RPL_WAIT: if (spi.done) begin
          state   <= RPH_SEND;
          spi.wrt <= 1'b1;
          spi.cmd <= 16'hA300;
        end
        RPH_WAIT: if (spi.done) begin
          state   <= RAL_SEND;
          spi.wrt <= 1'b1;
          spi.cmd <= 16'hAC00;
        end
        RAL_WAIT: if (spi.done) begin
          state   <= RAH_SEND;
          spi.wrt <= 1'b1;
          spi.cmd <= 16'hAD00;
        end
        // Both results load on the same edge so they are never seen half-updated.
        RAH_WAIT: if (spi.done) begin
          state   <= IDLE;
          ptch_rt <= signed'({p_hi, p_lo});
          AZ      <= signed'({spi.inert_data[7:0], az_lo});
          vld     <= 1'b1;
        end
        default: begin
          state     <= INIT_WAIT;
          spi.wrt   <= 1'b0;
          spi.cmd   <= 16'h0000;
          ptch_rt   <= '0;
          AZ        <= '0;
          vld       <= 1'b0;
          init_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inert_intf.sv
// ---------------------------------------------------------------------------
// tb_inert_intf
// Bench for inert_intf with a 4-bit power-on timer. Contains an SPI monarch
// model that answers every wrt with done after a programmable latency, a
// command-order model, a result scoreboard built from the bytes the monarch
// model returned, a table of directed read vectors and hand-written
// sequences for start-up timing, back-to-back reads and mid-transfer reset.
// ---------------------------------------------------------------------------
module tb_inert_intf;

  logic        clk;
  logic        rst_n;
  logic        int_in;
  logic [15:0] ptch_rt;
  logic [15:0] az;
  logic        vld;
  logic        init_done;

  inert_intf_if bus ();

  inert_intf #(.RST_WAIT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .INT       (int_in),
    .spi       (bus),
    .ptch_rt   (ptch_rt),
    .AZ        (az),
    .vld       (vld),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event at %0t", name, $time);
  endtask

  // Commands expected in order since reset: four config writes, then reads
  // repeating in groups of four.
  function automatic logic [15:0] exp_cmd(input int n);
    if (n < 4) begin
      case (n)
        0:       return 16'h0D02;
        1:       return 16'h1053;
        2:       return 16'h1150;
        default: return 16'h1460;
      endcase
    end
    case ((n - 4) % 4)
      0:       return 16'hA200;
      1:       return 16'hA300;
      2:       return 16'hAC00;
      default: return 16'hAD00;
    endcase
  endfunction

  // SPI monarch model and monitors (all sampled on the falling edge)
  logic [7:0]  rsp_q[$];
  logic [31:0] exp_q[$];
  int          lat = 40;
  bit          rnd_lat = 0;
  int          wrt_n = 0;
  int          done_n = 0;
  int          cnt = 0;
  bit          busy = 0;
  bit          stable_ok = 1;
  logic [15:0] cur_cmd = 16'h0;
  logic [7:0]  m_pl = 8'h0, m_ph = 8'h0, m_al = 8'h0;
  logic        prev_vld = 1'b0;
  logic [31:0] prev_out = 32'h0;

  always @(negedge clk) begin
    logic [7:0] b;
    logic [31:0] e;
    if (!rst_n) begin
      wrt_n = 0;
      done_n = 0;
      busy = 0;
      cnt = 0;
      bus.done = 1'b0;
      bus.inert_data = 16'h0;
      exp_q.delete();
    end else begin
      if (!vld) check("out_hold", {ptch_rt, az}, prev_out);
      if (vld) begin
        check("vld_one_cycle", prev_vld, 1'b0);
        check("sb_pending", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_result", {ptch_rt, az}, e);
        end
      end
      if (bus.wrt) begin
        check("wrt_while_busy", busy, 1'b0);
        check("cmd_order", bus.cmd, exp_cmd(wrt_n));
        wrt_n++;
        busy = 1;
        cur_cmd = bus.cmd;
        stable_ok = 1;
        cnt = rnd_lat ? int'($urandom_range(1, 12)) : lat;
        bus.done = 1'b0;
      end else if (busy) begin
        if (bus.cmd !== cur_cmd) stable_ok = 0;
        cnt--;
        if (cnt == 0) begin
          if (cur_cmd[15] && rsp_q.size() != 0) b = rsp_q.pop_front();
          else b = 8'($urandom);
          bus.inert_data = {8'($urandom), b};
          bus.done = 1'b1;
          busy = 0;
          done_n++;
          check("cmd_stable", stable_ok, 1'b1);
          case (cur_cmd)
            16'hA200: m_pl = b;
            16'hA300: m_ph = b;
            16'hAC00: m_al = b;
            16'hAD00: exp_q.push_back({m_ph, m_pl, b, m_al});
            default: ;
          endcase
        end
      end
    end
    prev_vld = vld;
    prev_out = {ptch_rt, az};
  end

  // Directed read vectors
  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [15:0] p, a;
  } vec_t;
  vec_t vecs[4];

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_vld(output bit ok);
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      cycles(1);
      if (vld) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail("vld_timeout");
  endtask

  // Called one step after a rising edge; releases reset between edges.
  task automatic release_and_time();
    int n;
    bit seen;
    #2 rst_n = 1'b1;
    n = 0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.wrt) begin
        seen = 1;
        break;
      end
    end
    if (!seen) fail("first_wrt_timeout");
    else begin
      check("first_wrt_cycles", n, 16);
      check("first_cmd", bus.cmd, 16'h0D02);
    end
  endtask

  task automatic wait_init();
    bit ok;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      cycles(1);
      if (init_done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail("init_timeout");
    else begin
      check("init_with_4th_done", done_n, 4);
      check("cfg_wrt_count", wrt_n, 4);
    end
  endtask

  task automatic push_bytes(input logic [7:0] b0, b1, b2, b3);
    rsp_q.push_back(b0);
    rsp_q.push_back(b1);
    rsp_q.push_back(b2);
    rsp_q.push_back(b3);
  endtask

  task automatic run_vec(input int i);
    bit ok;
    int w0;
    push_bytes(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
    int_in = 1'b1;
    cycles(2);
    int_in = 1'b0;
    wait_vld(ok);
    if (ok) begin
      check("vec_ptch", ptch_rt, vecs[i].p);
      check("vec_az", az, vecs[i].a);
      cycles(1);
      check("vec_vld_pulse", vld, 1'b0);
      w0 = wrt_n;
      cycles(15);
      check("vec_ptch_held", ptch_rt, vecs[i].p);
      check("vec_az_held", az, vecs[i].a);
      check("vec_no_new_rd", wrt_n, w0);
    end
  endtask

  initial begin
    bit ok;
    int n, w0;
    logic [7:0] r0, r1, r2, r3;

    rst_n  = 1'b0;
    int_in = 1'b0;
    vecs[0] = '{8'h34, 8'h12, 8'h78, 8'h56, 16'h1234, 16'h5678};
    vecs[1] = '{8'hCD, 8'hAB, 8'h01, 8'h80, 16'hABCD, 16'h8001};
    vecs[2] = '{8'hFF, 8'h7F, 8'h00, 8'h80, 16'h7FFF, 16'h8000};
    vecs[3] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 16'h0000, 16'hFFFF};

    cycles(3);
    check("rst_wrt", bus.wrt, 1'b0);
    check("rst_cmd", bus.cmd, 16'h0);
    check("rst_ptch", ptch_rt, 16'h0);
    check("rst_az", az, 16'h0);
    check("rst_vld", vld, 1'b0);
    check("rst_init_done", init_done, 1'b0);

    // Start-up timing, with INT pulsed while configuring
    release_and_time();
    int_in = 1'b1;
    cycles(5);
    int_in = 1'b0;
    wait_init();
    w0 = wrt_n;
    cycles(20);
    check("int_ignored_pre_init", wrt_n, w0);

    for (int i = 0; i < 4; i++) run_vec(i);

    // Back-to-back reads with INT held high
    push_bytes(8'h34, 8'h12, 8'h78, 8'h56);
    push_bytes(8'hCD, 8'hAB, 8'h01, 8'h80);
    int_in = 1'b1;
    wait_vld(ok);
    if (ok) begin
      check("b2b_ptch0", ptch_rt, 16'h1234);
      check("b2b_az0", az, 16'h5678);
      n = 0;
      ok = 0;
      for (int i = 0; i < 10; i++) begin
        cycles(1);
        n++;
        if (bus.wrt) begin
          ok = 1;
          break;
        end
      end
      if (!ok) fail("b2b_restart_timeout");
      else check("b2b_restart_gap", n, 1);
    end
    int_in = 1'b0;
    wait_vld(ok);
    if (ok) begin
      check("b2b_ptch1", ptch_rt, 16'hABCD);
      check("b2b_az1", az, 16'h8001);
    end
    w0 = wrt_n;
    cycles(60);
    check("b2b_stops", wrt_n, w0);

    // Random bytes and monarch latency
    rnd_lat = 1;
    for (int k = 0; k < 20; k++) begin
      r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
      push_bytes(r0, r1, r2, r3);
      int_in = 1'b1;
      cycles(int'($urandom_range(1, 3)));
      int_in = 1'b0;
      wait_vld(ok);
      if (ok) begin
        check("rnd_ptch", ptch_rt, {r1, r0});
        check("rnd_az", az, {r3, r2});
      end
      cycles(int'($urandom_range(0, 4)));
    end
    rnd_lat = 0;

    // Reset while waiting on the 0xAC00 read
    push_bytes(8'h11, 8'h22, 8'h33, 8'h44);
    int_in = 1'b1;
    cycles(2);
    int_in = 1'b0;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      cycles(1);
      if (bus.wrt && bus.cmd == 16'hAC00) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail("ac00_timeout");
    cycles(10);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_wrt", bus.wrt, 1'b0);
    check("mid_rst_cmd", bus.cmd, 16'h0);
    check("mid_rst_ptch", ptch_rt, 16'h0);
    check("mid_rst_az", az, 16'h0);
    check("mid_rst_vld", vld, 1'b0);
    check("mid_rst_init_done", init_done, 1'b0);
    rsp_q.delete();
    cycles(3);
    release_and_time();
    wait_init();
    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inert_intf.md
Name: inert_intf

Overview:
- SPI command sequencer that sits directly upstream of the team's 16-bit SPI monarch (master) and drives its wrt/wt_data inputs.
- Consumes the master's done/rd_data outputs.
- After a power-on wait, it programs the 6-axis inertial sensor with four configuration writes.
- It then performs a 4-transaction read of pitch rate and Z acceleration on each data-ready interrupt, and presents the assembled 16-bit results with a one-cycle valid strobe to the balance controller.

Parameters:
RST_WAIT_W, 16, width of the power-on wait timer; configuration starts when the timer reaches all-ones (bench uses 4).

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
INT  input  1  sensor data-ready interrupt, asynchronous, active-high level
done  input  1  SPI master transaction complete; level, cleared by master the cycle after wrt
inert_data  input  16  SPI master rd_data; only [7:0] used
wrt  output  1  one-cycle pulse starting an SPI transaction
cmd  output  16  SPI command word to master wt_data
ptch_rt  output  16  signed pitch rate {high byte, low byte}
AZ  output  16  signed Z acceleration {high byte, low byte}
vld  output  1  one-cycle strobe: ptch_rt and AZ updated
init_done  output  1  high once all configuration writes have completed

Behaviour:
- Reset values: wrt=0, cmd=0, ptch_rt=0, AZ=0, vld=0, init_done=0, timer=0, FSM=INIT_WAIT, INT sync flops=0. Reset asserted at any point (including mid-transaction) returns everything to these values, and the power-on wait restarts.
- INT is double-flop synchronised; only the synchronised version (INT_ff2) is used.
- Timer: RST_WAIT_W-bit up-counter, enabled only in INT_WAIT. Width rule: no saturation is needed because the FSM leaves on all-ones.
- Transaction handshake, used for every command:
  - SEND cycle: wrt=1 and cmd driven.
  - FSM moves to the matching WAIT state.
  - cmd is held stable from the SEND cycle until done is seen.
  - done is sampled only in WAIT states; the first WAIT cycle follows wrt, by which time the master has cleared done.
  - The next SEND occurs no earlier than the cycle after done is seen.
- States and transitions:
  - INIT_WAIT: timer==all-ones -> CFG0_SEND.
  - CFG0..CFG3 (SEND/WAIT pairs), commands in order: 0x0D02 (INT on data-ready), 0x1053 (accel ODR 208 Hz), 0x1150 (gyro ODR 208 Hz), 0x1460 (rounding).
  - CFG3 WAIT with done -> IDLE, and init_done is set (sticky until reset).
  - IDLE: INT_ff2==1 -> RPL_SEND; otherwise stay. INT seen before init_done is ignored, with no reads issued.
  - RPL: cmd 0xA200; on done latch inert_data[7:0] into the pitch-low holding register.
  - RPH: cmd 0xA300; on done latch the pitch-high holding register.
  - RAL: cmd 0xAC00; on done latch the AZ-low holding register.
  - RAH: cmd 0xAD00; on done, on the same clock edge, load ptch_rt={pH,pL} and AZ={inert_data[7:0],aL}, pulse vld next cycle-visible, and go to IDLE.
- Output update rule: ptch_rt and AZ change only together and only on the vld edge; they are never partially updated.
- Latency: vld is high in the cycle following the final done, for exactly one cycle.
- INT still high on return to IDLE: a new read sequence starts immediately (level-triggered). Earliest next wrt is 1 cycle after vld.
- Unused/illegal state -> INIT_WAIT with outputs at reset values.
- wrt never asserts twice without an intervening done, and never asserts before the timer expires.

Test Plan:
- RST_WAIT_W=4, release reset -> first wrt exactly 16 cycles after release (±1 documented), cmd=0x0D02; no wrt earlier.
- SPI model returns done 40 cycles after each wrt -> wrt pulses carry 0x0D02, 0x1053, 0x1150, 0x1460 in order, one per done; init_done rises with the 4th done; cmd stable between each wrt and its done.
- INT pulsed high during configuration -> no 0xA2xx command is issued, and the post-init sequence is unaffected.
- After init, INT high then low; model returns read bytes 0x34, 0x12, 0x78, 0x56 -> cmds 0xA200, 0xA300, 0xAC00, 0xAD00; ptch_rt=0x1234, AZ=0x5678; vld high exactly 1 cycle; outputs unchanged until the next vld.
- INT held high; second read returns 0xCD, 0xAB, 0x01, 0x80 -> back-to-back sequences; second vld gives ptch_rt=0xABCD and AZ=0x8001.
- Reset asserted while waiting on done for 0xAC00 -> all outputs 0 immediately; init_done=0; after release, the power-on wait and all four configuration writes repeat.
